// File: rtl/ikaopll_acc_mixdac_if.sv
// Sample-path bus of the OPLL accumulating mixing DAC.
// The master is the operator/percussion side; the slave is the DAC.
interface ikaopll_acc_mixdac_if #(
  parameter int SAMPLE_W = 9,
  parameter int VOL_W    = 5,
  parameter int OUT_W    = 16
);
  logic                i_CYCLE_00;
  logic                i_SMP_VALID;
  logic                i_RO_CTRL;
  logic [SAMPLE_W-1:0] i_SMP;
  logic [VOL_W-1:0]    i_MOVOL;
  logic [VOL_W-1:0]    i_ROVOL;
  logic [OUT_W-1:0]    o_ACC_SIGNED;
  logic                o_ACC_SIGNED_STRB;
  logic                o_ACC_SAT;

  modport master (
    output i_CYCLE_00, i_SMP_VALID, i_RO_CTRL, i_SMP, i_MOVOL, i_ROVOL,
    input  o_ACC_SIGNED, o_ACC_SIGNED_STRB, o_ACC_SAT
  );
  modport slave (
    input  i_CYCLE_00, i_SMP_VALID, i_RO_CTRL, i_SMP, i_MOVOL, i_ROVOL,
    output o_ACC_SIGNED, o_ACC_SIGNED_STRB, o_ACC_SAT
  );
endinterface

// File: rtl/ikaopll_acc_mixdac.sv
// Frame-accumulating mixing DAC: volume-scaled slot sum, shift, saturate, strobe.
// Define IKAOPLL_ACC_DAC_ERRFB_EN to carry truncated bits into the next frame.
module ikaopll_acc_mixdac #(
  parameter int SAMPLE_W  = 9,
  parameter int VOL_W     = 5,
  parameter int FRAME_LEN = 18,
  parameter int CYC_DLY   = 3,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 1,
  parameter int STRB_LEN  = 9
) (
  input  logic                i_EMUCLK,
  input  logic                i_RST_n,
  input  logic                i_phi1_NCEN_n,
  ikaopll_acc_mixdac_if.slave bus
);
  localparam int PW    = SAMPLE_W + VOL_W;
  localparam int ACC_W = PW + $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(STRB_LEN + 1);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);

  logic signed [SAMPLE_W-1:0] v;
  logic signed [VOL_W-1:0]    vol;
  logic signed [PW-1:0]       p;
  logic signed [ACC_W-1:0]    p_x, acc, s, seed;
  logic [CYC_DLY-1:0]         dly;
  logic [CNT_W-1:0]           cnt;
  logic                       bnd, clip_hi, clip_lo;
  logic [OUT_W-1:0]           out_q;
  logic                       sat_q, strb_q;

  assign bnd = dly[CYC_DLY-1];

  // ~{0,mag} == -(mag+1): sign+magnitude without a negative zero
  always_comb begin
    v   = bus.i_SMP[SAMPLE_W-1] ? ~{1'b0, bus.i_SMP[SAMPLE_W-2:0]}
                                :  {1'b0, bus.i_SMP[SAMPLE_W-2:0]};
    vol = bus.i_RO_CTRL ? bus.i_ROVOL : bus.i_MOVOL;
    p   = bus.i_SMP_VALID ? PW'(v) * PW'(vol) : '0;
    p_x = ACC_W'(p);
  end

  always_comb begin
    s       = acc >>> OUT_SHIFT;
    clip_hi = s > S_MAX;
    clip_lo = s < S_MIN;
  end

`ifdef IKAOPLL_ACC_DAC_ERRFB_EN
  generate
    if (OUT_SHIFT > 0) begin : g_res
      assign seed = ACC_W'(acc[OUT_SHIFT-1:0]);
    end else begin : g_nores
      assign seed = '0;
    end
  endgenerate
`else
  assign seed = '0;
`endif

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      acc    <= '0;
      dly    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      sat_q  <= 1'b0;
      strb_q <= 1'b0;
    end else if (!i_phi1_NCEN_n) begin
      dly    <= (dly << 1) | CYC_DLY'(bus.i_CYCLE_00);
      // strobe trails the count by one cycle so it rises after the data update
      strb_q <= cnt != '0;
      if (bnd) begin
        out_q <= clip_hi ? S_MAX[OUT_W-1:0] : clip_lo ? S_MIN[OUT_W-1:0] : s[OUT_W-1:0];
        sat_q <= clip_hi | clip_lo;
        acc   <= seed + p_x;
        cnt   <= CNT_W'(STRB_LEN);
      end else begin
        acc <= acc + p_x;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.o_ACC_SIGNED      = out_q;
  assign bus.o_ACC_SAT         = sat_q;
  assign bus.o_ACC_SIGNED_STRB = strb_q;
endmodule

// File: tb/tb_ikaopll_acc_mixdac.sv
// Directed bench for ikaopll_acc_mixdac; each frame call checks the previous frame's result.
module tb_ikaopll_acc_mixdac;
  logic emuclk = 1'b0;
  logic rst_n  = 1'b0;
  logic ncen_n = 1'b0;
  bit   tog    = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 emuclk = ~emuclk;

  ikaopll_acc_mixdac_if bus ();

  ikaopll_acc_mixdac dut (
    .i_EMUCLK      (emuclk),
    .i_RST_n       (rst_n),
    .i_phi1_NCEN_n (ncen_n),
    .bus           (bus.slave)
  );

`ifdef IKAOPLL_ACC_DAC_ERRFB_EN
  localparam int EFB2 = 1;
`else
  localparam int EFB2 = 0;
`endif

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // One enabled cycle; in toggle mode it is preceded by a disabled cycle carrying junk.
  task automatic cyc(input logic c0, input logic vld, input logic ro, input logic [8:0] smp);
    if (tog) begin
      ncen_n = 1'b1;
      bus.i_CYCLE_00 = 1'b1; bus.i_SMP_VALID = 1'b1; bus.i_RO_CTRL = 1'b0;
      bus.i_SMP = 9'($urandom);
      @(posedge emuclk); #1;
    end
    ncen_n = 1'b0;
    bus.i_CYCLE_00 = c0; bus.i_SMP_VALID = vld; bus.i_RO_CTRL = ro; bus.i_SMP = smp;
    @(posedge emuclk); #1;
  endtask

  // j=0 is a boundary cycle; i_CYCLE_00 at j=len-3 puts the next boundary at j=len.
  task automatic frame(input string nm, input int len, input int nvld, input logic ro,
                       input logic [8:0] smp, input logic [4:0] mv, input logic [4:0] rv,
                       input int exp_out, input bit exp_sat, input bit exp_s0);
    bus.i_MOVOL = mv;
    bus.i_ROVOL = rv;
    for (int j = 0; j < len; j++) begin
      cyc(j == len - 3, j < nvld, ro, smp);
      if (j == 0) begin
        chk({nm, ".out"},   32'($signed(bus.o_ACC_SIGNED)), exp_out);
        chk({nm, ".sat"},   32'(bus.o_ACC_SAT), 32'(exp_sat));
        chk({nm, ".strb0"}, 32'(bus.o_ACC_SIGNED_STRB), 32'(exp_s0));
      end
      if (j == 1) chk({nm, ".strb1"}, 32'(bus.o_ACC_SIGNED_STRB), 1);
      if (j == 9) begin
        chk({nm, ".strb9"}, 32'(bus.o_ACC_SIGNED_STRB), 1);
        chk({nm, ".hold"},  32'($signed(bus.o_ACC_SIGNED)), exp_out);
      end
      if (j == 10) chk({nm, ".strb10"}, 32'(bus.o_ACC_SIGNED_STRB), 0);
    end
  endtask

  initial begin
    bus.i_CYCLE_00 = 1'b0; bus.i_SMP_VALID = 1'b0; bus.i_RO_CTRL = 1'b0;
    bus.i_SMP = '0; bus.i_MOVOL = 5'd3; bus.i_ROVOL = 5'd7;

    // reset across enabled and disabled edges with busy inputs
    rst_n = 1'b0;
    tog   = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 9'h0AA);
    tog = 1'b0;
    chk("rst.out",  32'($signed(bus.o_ACC_SIGNED)), 0);
    chk("rst.sat",  32'(bus.o_ACC_SAT), 0);
    chk("rst.strb", 32'(bus.o_ACC_SIGNED_STRB), 0);

    // partial frame after release: 3 x (10*2) = 60 -> 30
    rst_n = 1'b1;
    bus.i_MOVOL = 5'd2;
    cyc(1'b1, 1'b1, 1'b0, {1'b0, 8'd10});
    cyc(1'b0, 1'b1, 1'b0, {1'b0, 8'd10});
    cyc(1'b0, 1'b1, 1'b0, {1'b0, 8'd10});

    frame("single", 18, 1,  1'b0, {1'b0, 8'd100}, 5'd3, 5'd0,  30,     1'b0, 1'b0);
    frame("rovol",  18, 4,  1'b1, {1'b1, 8'd0},   5'd0, 5'h10, 150,    1'b0, 1'b0); // -1 * -16
    frame("movol0", 18, 4,  1'b0, {1'b1, 8'd0},   5'd0, 5'h10, 32,     1'b0, 1'b0);
    frame("satpos", 18, 18, 1'b1, {1'b1, 8'd255}, 5'd0, 5'h10, 0,      1'b0, 1'b0);
    frame("satneg", 18, 18, 1'b1, {1'b1, 8'd255}, 5'd0, 5'h0F, 32767,  1'b1, 1'b0);
    frame("efb1",   18, 1,  1'b0, {1'b0, 8'd1},   5'd1, 5'd0,  -32768, 1'b1, 1'b0);
    frame("efb2",   18, 1,  1'b0, {1'b0, 8'd1},   5'd1, 5'd0,  0,      1'b0, 1'b0);
    frame("idle",   18, 0,  1'b0, 9'd0,           5'd0, 5'd0,  EFB2,   1'b0, 1'b0);

    // 1:1 clock enable must match the always-enabled results
    tog = 1'b1;
    frame("t_single", 18, 1,  1'b0, {1'b0, 8'd100}, 5'd3, 5'd0,  0,     1'b0, 1'b0);
    frame("t_sat",    18, 18, 1'b1, {1'b1, 8'd255}, 5'd0, 5'h10, 150,   1'b0, 1'b0);
    frame("t_idle",   18, 0,  1'b0, 9'd0,           5'd0, 5'd0,  32767, 1'b1, 1'b0);
    tog = 1'b0;

    // frame start 5 cycles after a boundary: strobe must restart with no gap
    frame("b2b",   8,  2, 1'b0, {1'b0, 8'd50}, 5'd1, 5'd0, 0,  1'b0, 1'b0);
    frame("after", 18, 0, 1'b0, 9'd0,          5'd0, 5'd0, 50, 1'b0, 1'b1);
    frame("end",   18, 0, 1'b0, 9'd0,          5'd0, 5'd0, 0,  1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ikaopll_acc_mixdac.md
# ikaopll_acc_mixdac

Frame-accumulating 16-bit mixing DAC for the OPLL core. Sits after the operator output / percussion sample path and replaces the impulse-per-slot DAC outputs with one signed PCM word per sample frame. Each enabled slot's sign+magnitude operator sample is scaled by a signed per-group (melody/rhythm) volume and summed over the frame. The sum is shifted, saturated and presented with a timed strobe. Intended for FPGA/ASIC hosts that need a conventional PCM stream.

## Interface
Parameters:
- SAMPLE_W, 9, sign+magnitude input width (1 sign + SAMPLE_W-1 magnitude)
- VOL_W, 5, signed volume width
- FRAME_LEN, 18, enabled cycles per frame; sizes the accumulator
- CYC_DLY, 3, enabled cycles from i_CYCLE_00 to the internal frame boundary
- OUT_W, 16, output width
- OUT_SHIFT, 1, arithmetic right shift applied before saturation
- STRB_LEN, 9, strobe high time in enabled cycles

Ports:
- i_EMUCLK  in  1  master clock; sole clock
- i_RST_n  in  1  reset, synchronous, active-low
- i_phi1_NCEN_n  in  1  clock enable, active-low; all state advances only when low
- i_CYCLE_00  in  1  frame-start marker, one enabled cycle wide
- i_SMP_VALID  in  1  current slot carries a DAC sample (~inhibit & (MO|RO) window)
- i_RO_CTRL  in  1  1 = rhythm slot (use RO volume), 0 = melody slot
- i_SMP  in  SAMPLE_W  sign+magnitude sample, bit SAMPLE_W-1 = sign
- i_MOVOL  in  VOL_W  signed melody volume
- i_ROVOL  in  VOL_W  signed rhythm volume
- o_ACC_SIGNED  out  OUT_W  signed frame sum
- o_ACC_SIGNED_STRB  out  1  output-valid strobe
- o_ACC_SAT  out  1  1 = current o_ACC_SIGNED was clipped

## Operation
- Sample decode: v = sign ? -(mag+1) : mag. This is one's-complement style with no negative zero. Range is -2^(SAMPLE_W-1)..2^(SAMPLE_W-1)-1, i.e. -256..255.
- Product p = v * (i_RO_CTRL ? i_ROVOL : i_MOVOL), signed, SAMPLE_W+VOL_W bits. p = 0 when i_SMP_VALID = 0.
- Accumulator ACC_W = SAMPLE_W+VOL_W+clog2(FRAME_LEN) bits signed (19 by default). It cannot wrap within one frame.
- Boundary delay line: i_CYCLE_00 is shifted through a CYC_DLY-stage shift register. Its last stage is `bnd`.
- On an enabled cycle with bnd = 0: acc <= acc + p.
- On an enabled cycle with bnd = 1:
  - s = acc >>> OUT_SHIFT.
  - o_ACC_SIGNED <= s clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_ACC_SAT <= (clip occurred).
  - acc <= seed + p, where seed is defined under Configuration. The current slot's product starts the new frame.
  - The strobe counter loads.
- Strobe: o_ACC_SIGNED_STRB rises 1 enabled cycle after bnd and stays high for STRB_LEN enabled cycles. A new bnd while the strobe is high restarts the count; the strobe stays high without a gap.
- Frame with no i_CYCLE_00: the accumulator keeps summing and no output is produced. The width guarantee holds only for ≤ FRAME_LEN cycles; beyond that the sum wraps modulo 2^ACC_W and this is legal.

## Timing
- Reset (i_RST_n low on an i_EMUCLK edge, regardless of enable) clears: acc, delay line, strobe counter, o_ACC_SIGNED = 0, o_ACC_SIGNED_STRB = 0, o_ACC_SAT = 0, residual = 0.
- Reset is effective on the same edge. Deasserting mid-frame starts a partial frame; its first output is emitted normally at the next bnd.
- Latency: i_CYCLE_00 → o_ACC_SIGNED update = CYC_DLY enabled cycles → strobe rise +1 enabled cycle.
- o_ACC_SIGNED and o_ACC_SAT are stable from the bnd update until the next bnd.
- Disabled cycles (i_phi1_NCEN_n = 1) hold all state, including the delay line and strobe counter.
- Simultaneous i_CYCLE_00 and bnd (period < CYC_DLY) are both honoured independently.

## Configuration
- IKAOPLL_ACC_DAC_ERRFB_EN defined: error feedback (first-order noise shaping).
  - At bnd, residual = acc[OUT_SHIFT-1:0], zero-extended.
  - seed = residual, so truncated bits carry into the next frame.
  - No effect when OUT_SHIFT = 0.
- Not defined: seed = 0 and plain truncation; the residual register is not built.

## Test plan
- Reset: hold i_RST_n = 0 for 4 enabled cycles with nonzero inputs -> all outputs 0, strobe 0; first bnd after release outputs only the post-reset partial sum.
- Single slot: frame with one valid sample {sign=0, mag=100}, MOVOL = 3, others invalid -> o_ACC_SIGNED = 150 (300>>>1), SAT = 0; strobe rises CYC_DLY+1 enabled cycles after i_CYCLE_00 and lasts 9.
- Sign/volume: sample {sign=1, mag=0} (v = -1) with ROVOL = -16, i_RO_CTRL = 1, 4 slots -> sum 64 -> output 32; same slots with MOVOL selected (RO_CTRL = 0, MOVOL = 0) -> 0.
- Saturation: 18 slots of {1, 255} (v = -256) × vol -16 -> acc 73728 -> s 36864 -> o_ACC_SIGNED = 32767, o_ACC_SAT = 1. Vol +15 with the same slots -> -69120 >>> 1 = -34560 -> -32768, SAT = 1.
- Error feedback: OUT_SHIFT = 1, one frame with a single sample v = 1, vol = 1 -> output 0 in both builds. Next frame identical -> 1 with IKAOPLL_ACC_DAC_ERRFB_EN, 0 without.
- Clock enable / back-to-back: i_phi1_NCEN_n toggling 1:1 and frames every 18 enabled cycles -> results identical to the always-enabled run. i_CYCLE_00 arriving 5 enabled cycles after the previous bnd -> strobe restarts with no low gap.
